// File: rtl/twowire_pkg.sv
// Shared definitions for the Two-Wire Debug Connect sequence (host generator and DTM monitor).
package twowire_pkg;

  localparam logic [5:0] LFSR_TAPS = 6'h30;
  localparam logic [5:0] LFSR_INIT = 6'h29;

  localparam int unsigned CONNECT_LFSR_BITS = 64;
  localparam int unsigned ADDR_BITS         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StSeq,
    StAddr
  } conn_state_e;

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], ^(s & LFSR_TAPS)};
  endfunction

  // Address frame is addr MSB-first followed by its complement MSB-first.
  function automatic logic addr_frame_bit(input logic [3:0] addr, input logic [2:0] idx);
    logic [7:0] frame;
    frame = {addr, ~addr};
    return frame[3'd7 - idx];
  endfunction

endpackage

// File: rtl/twowire_lfsr6.sv
// 6-bit Connect LFSR with load/advance enables; shared by the host generator and DTM monitor.
module twowire_lfsr6
  import twowire_pkg::*;
(
  input  logic clk_i,
  input  logic drst_ni,
  input  logic load_i,
  input  logic adv_i,
  output logic bit_o,
  output logic next_bit_o
);

  logic [5:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = LFSR_INIT;
    end else if (adv_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge drst_ni) begin
    if (!drst_ni) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o      = lfsr_q[5];
  // MSB after the next advance, so a bit can be launched in the same cycle the LFSR steps.
  assign next_bit_o = lfsr_q[4];

endmodule

// File: rtl/twowire_host_connect_gen.sv
// Host-side Two-Wire Debug Connect generator: preamble, 64 LFSR bits, address and complement
// serialised on DIO, with DCK derived from clk by integer division.
module twowire_host_connect_gen
  import twowire_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned CLKDIV       = 2
) (
  input  logic       clk,
  input  logic       drst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] mdropaddr,
  output logic       busy,
  output logic       done,
  output logic       dck_out,
  output logic       dio_out,
  output logic       dio_oe
);

  localparam logic [7:0] DivLast  = 8'(CLKDIV - 1);
  localparam logic [7:0] PreLast  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] SeqLast  = 8'(CONNECT_LFSR_BITS - 1);
  localparam logic [7:0] AddrLast = 8'(2 * ADDR_BITS - 1);

  conn_state_e state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  bit_q, bit_d;
  logic [7:0]  bit_inc;
  logic [3:0]  addr_q, addr_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dck_q, dck_d;
  logic        dio_q, dio_d;
  logic        to_idle;
  logic        lfsr_load, lfsr_adv;
  logic        lfsr_bit, lfsr_next_bit;

  twowire_lfsr6 u_lfsr (
    .clk_i      (clk),
    .drst_ni    (drst_n),
    .load_i     (lfsr_load),
    .adv_i      (lfsr_adv),
    .bit_o      (lfsr_bit),
    .next_bit_o (lfsr_next_bit)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    abort_d   = abort_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dck_d     = dck_q;
    dio_d     = dio_q;
    to_idle   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    bit_inc   = bit_q + 8'd1;

    if (state_q == StIdle) begin
      abort_d = 1'b0;
      if (start) begin
        state_d   = StPre;
        addr_d    = mdropaddr;
        busy_d    = 1'b1;
        dck_d     = 1'b0;
        dio_d     = 1'b0;
        div_d     = '0;
        bit_d     = '0;
        lfsr_load = 1'b1;
      end
    end else begin
      abort_d = abort_q | abort;
      if (div_q != DivLast) begin
        div_d = div_q + 8'd1;
      end else begin
        div_d = '0;
        dck_d = ~dck_q;
        // A falling DCK edge is the bit boundary: launch the next bit or leave.
        if (dck_q) begin
          bit_d = bit_inc;
          if (abort_q || abort) begin
            to_idle = 1'b1;
          end else begin
            unique case (state_q)
              StPre: begin
                if (bit_q == PreLast) begin
                  state_d = StSeq;
                  bit_d   = '0;
                  dio_d   = lfsr_bit;
                end else begin
                  dio_d = 1'b0;
                end
              end
              StSeq: begin
                lfsr_adv = 1'b1;
                if (bit_q == SeqLast) begin
                  state_d = StAddr;
                  bit_d   = '0;
                  dio_d   = addr_q[ADDR_BITS-1];
                end else begin
                  dio_d = lfsr_next_bit;
                end
              end
              StAddr: begin
                if (bit_q == AddrLast) begin
                  to_idle = 1'b1;
                  done_d  = 1'b1;
                end else begin
                  dio_d = addr_frame_bit(addr_q, bit_inc[2:0]);
                end
              end
              default: ;
            endcase
          end
        end
      end
    end

    if (to_idle) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      dio_d   = 1'b0;
      bit_d   = '0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge drst_n) begin
    if (!drst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dck_q   <= 1'b0;
      dio_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dck_q   <= dck_d;
      dio_q   <= dio_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dck_out = dck_q;
  assign dio_out = dio_q;
  assign dio_oe  = busy_q;

endmodule

// File: tb/tb_twowire_host_connect_gen.sv
// Directed bench for the Connect generator: full sequences, abort, held start, async reset,
// and a fast CLKDIV=1/PREAMBLE_LEN=1 instance.
module tb_twowire_host_connect_gen;

  logic       clk = 1'b0;
  logic       drst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] mdropaddr = 4'h0;
  logic       busy, done, dck_out, dio_out, dio_oe;

  logic       start_f = 1'b0;
  logic       abort_f = 1'b0;
  logic [3:0] mdropaddr_f = 4'h9;
  logic       busy_f, done_f, dck_f, dio_f, dio_oe_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  twowire_host_connect_gen u_dut (
    .clk       (clk),
    .drst_n    (drst_n),
    .start     (start),
    .abort     (abort),
    .mdropaddr (mdropaddr),
    .busy      (busy),
    .done      (done),
    .dck_out   (dck_out),
    .dio_out   (dio_out),
    .dio_oe    (dio_oe)
  );

  twowire_host_connect_gen #(
    .PREAMBLE_LEN (1),
    .CLKDIV       (1)
  ) u_fast (
    .clk       (clk),
    .drst_n    (drst_n),
    .start     (start_f),
    .abort     (abort_f),
    .mdropaddr (mdropaddr_f),
    .busy      (busy_f),
    .done      (done_f),
    .dck_out   (dck_f),
    .dio_out   (dio_f),
    .dio_oe    (dio_oe_f)
  );

  // Negedge monitor: captures DIO at each DCK rise and records timing of busy/done.
  logic bits[$];
  int   cyc = 0, rises = 0, done_cnt = 0, glitches = 0;
  int   busy_rise_cyc = 0, done_cyc = 0;
  logic busy_at_done = 1'b0;
  logic busy_p = 1'b0, dck_p = 1'b0, dio_p = 1'b0, rst_p = 1'b0;
  int   rises_f = 0, done_f_cnt = 0, toggle_err = 0;
  logic busy_fp = 1'b0, dck_fp = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_p) begin
      bits.delete();
      busy_rise_cyc = cyc;
    end
    if (dck_out && !dck_p) begin
      bits.push_back(dio_out);
      rises++;
    end
    if (drst_n && rst_p && (dio_out !== dio_p) && !(dck_p && !dck_out) && !(busy && !busy_p))
      glitches++;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    busy_p = busy;
    dck_p  = dck_out;
    dio_p  = dio_out;
    rst_p  = drst_n;

    if (dck_f && !dck_fp) rises_f++;
    if (done_f) done_f_cnt++;
    if (busy_f && busy_fp && (dck_f == dck_fp)) toggle_err++;
    busy_fp = busy_f;
    dck_fp  = dck_f;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] addr);
    mdropaddr = addr;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    int n = 0;
    while (done_cnt == prev && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic wait_rises(input string tag, input int target);
    int n = 0;
    while (rises < target && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_rises_reached"}, 64'(rises >= target), 64'd1);
  endtask

  // Independent reference for the 64 Connect LFSR bits (x^6 + x^5 + 1, seed 6'h29).
  function automatic logic [63:0] lfsr_stream();
    logic [5:0]  s;
    logic [63:0] r;
    s = 6'h29;
    for (int i = 0; i < 64; i++) begin
      r[63-i] = s[5];
      s       = {s[4:0], s[5] ^ s[4]};
    end
    return r;
  endfunction

  task automatic check_run(input string tag, input logic [7:0] addr_frame);
    logic        pre_any;
    logic [63:0] seq;
    logic [7:0]  adr;
    check({tag, "_nbits"}, 64'(bits.size()), 64'd80);
    check({tag, "_done_latency"}, 64'(done_cyc - busy_rise_cyc), 64'd320);
    check({tag, "_busy_with_done"}, 64'(busy_at_done), 64'd0);
    if (bits.size() == 80) begin
      pre_any = 1'b0;
      for (int i = 0; i < 8; i++) pre_any |= bits[i];
      for (int i = 0; i < 64; i++) seq[63-i] = bits[8+i];
      for (int i = 0; i < 8; i++) adr[7-i] = bits[72+i];
      check({tag, "_preamble"}, 64'(pre_any), 64'd0);
      check({tag, "_lfsr_first8"}, 64'(seq[63:56]), 64'h0a7);
      check({tag, "_lfsr_bit64"}, 64'(seq[0]), 64'd1);
      check({tag, "_lfsr_all"}, seq, lfsr_stream());
      check({tag, "_addr"}, 64'(adr), 64'(addr_frame));
    end
  endtask

  initial begin
    int d0;
    int r0;

    // Reset state
    #12;
    check("reset_outputs", 64'({busy, done, dck_out, dio_out, dio_oe}), 64'd0);
    drst_n = 1'b1;
    step();
    check("idle_outputs", 64'({busy, done, dck_out, dio_out, dio_oe}), 64'd0);

    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    step();
    abort = 1'b0;
    check("abort_idle", 64'({busy, dck_out}), 64'd0);

    // Full sequence with address 4'hA; fast instance runs alongside
    d0      = done_cnt;
    start_f = 1'b1;
    pulse_start(4'hA);
    start_f = 1'b0;
    check("busy_after_start", 64'({busy, dio_oe}), 64'b11);
    wait_done("run_a", d0);
    check_run("run_a", 8'b1010_0101);
    check("fast_rises", 64'(rises_f), 64'd73);
    check("fast_done", 64'(done_f_cnt), 64'd1);
    check("fast_toggle", 64'(toggle_err), 64'd0);
    step();
    check("idle_after_a", 64'({busy, dck_out, dio_out, dio_oe}), 64'd0);

    // Abort during the 10th LFSR bit
    d0 = done_cnt;
    r0 = rises;
    pulse_start(4'h3);
    wait_rises("abort", r0 + 18);
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int n = 0; n < 20 && busy; n++) step();
    check("abort_idle_state", 64'({busy, dck_out, dio_out, dio_oe}), 64'd0);
    check("abort_rises", 64'(rises - r0), 64'd18);
    repeat (10) step();
    check("abort_no_done", 64'(done_cnt), 64'(d0));

    // Restart after abort: LFSR must start again from the seed
    pulse_start(4'h3);
    wait_done("restart", d0);
    check_run("restart", 8'b0011_1100);

    // start held high, with a re-pulse mid-sequence and an address change while busy
    d0        = done_cnt;
    mdropaddr = 4'hC;
    start     = 1'b1;
    step();
    repeat (40) step();
    start = 1'b0;
    step();
    start     = 1'b1;
    mdropaddr = 4'h5;
    wait_done("held1", d0);
    check_run("held1", 8'b1100_0011);
    check("held_restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done("held2", d0 + 1);
    check_run("held2", 8'b0101_1010);
    step();
    check("held_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of ADDR
    d0 = done_cnt;
    r0 = rises;
    pulse_start(4'hA);
    wait_rises("rst", r0 + 75);
    #2;
    drst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({busy, done, dck_out, dio_out, dio_oe}), 64'd0);
    repeat (5) step();
    drst_n = 1'b1;
    step();
    check("rst_no_done", 64'(done_cnt), 64'(d0));
    pulse_start(4'hA);
    wait_done("after_rst", d0);
    check_run("after_rst", 8'b1010_0101);

    check("dio_stable_while_dck", 64'(glitches), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
